// File: rtl/bsg_cgol_input_data_channel_if.sv
// Host-link ingress bundle for the CGOL input data channel: the 64-bit word
// stream in (valid/ready) and the assembled board out (valid/yumi).
interface bsg_cgol_input_data_channel_if #(
  parameter int cells_p        = 64,
  parameter int frames_width_p = 32
);
  logic [63:0]               data_i;
  logic                      v_i;
  logic                      ready_and_o;
  logic [cells_p-1:0]        data_o;
  logic [frames_width_p-1:0] frames_o;
  logic                      v_o;
  logic                      yumi_i;
  logic                      err_o;

  modport slave (
    input  data_i, v_i, yumi_i,
    output ready_and_o, data_o, frames_o, v_o, err_o
  );

  modport master (
    output data_i, v_i, yumi_i,
    input  ready_and_o, data_o, frames_o, v_o, err_o
  );
endinterface

// File: rtl/bsg_cgol_input_data_channel.sv
// CGOL ingress: header word (generation count) then board words, assembled into
// one board register and offered downstream. BSG_CGOL_INPUT_PAD_CHECK_EN enables the sticky padding check.
module bsg_cgol_input_data_channel #(
  parameter int board_width_p  = 8,
  parameter int frames_width_p = 32
) (
  input logic clk_i,
  input logic reset_n_i,
  bsg_cgol_input_data_channel_if.slave ch
);

  localparam int num_total_cells_lp = board_width_p * board_width_p;
  localparam int data_words_lp      = (num_total_cells_lp + 63) / 64;
  localparam int ctr_width_lp       = (data_words_lp > 1) ? $clog2(data_words_lp) : 1;
  localparam int padded_width_lp    = 64 * data_words_lp;

  typedef enum logic [1:0] {
    S_HEADER,
    S_DATA,
    S_OUT
  } state_e;

  state_e                        state_q, state_d;
  logic [ctr_width_lp-1:0]       ctr_q, ctr_d;
  logic [num_total_cells_lp-1:0] board_q, board_d;
  logic [frames_width_p-1:0]     frames_q, frames_d;
  logic [padded_width_lp-1:0]    board_wide;
  logic                          last_word;
  logic                          data_xfer;

  assign last_word = (ctr_q == ctr_width_lp'(data_words_lp - 1));
  assign data_xfer = (state_q == S_DATA) && ch.v_i;

  // NOTE: every signal gets its hold value before the case, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    ctr_d      = ctr_q;
    board_d    = board_q;
    frames_d   = frames_q;
    board_wide = padded_width_lp'(board_q);
    unique case (state_q)
      S_HEADER: begin
        if (ch.v_i) begin
          frames_d = ch.data_i[frames_width_p-1:0];
          ctr_d    = '0;
          state_d  = S_DATA;
        end
      end
      S_DATA: begin
        if (ch.v_i) begin
          // The widened copy lets the final word spill past the board; those bits are dropped.
          board_wide[{ctr_q, 6'b0} +: 64] = ch.data_i;
          board_d = board_wide[num_total_cells_lp-1:0];
          if (last_word) state_d = S_OUT;
          else           ctr_d   = ctr_q + 1'b1;
        end
      end
      S_OUT: begin
        if (ch.yumi_i) state_d = S_HEADER;
      end
      default: state_d = S_HEADER;
    endcase
  end

  // NOTE: state registers use non-blocking assignment so all flops update together from pre-edge values.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      state_q  <= S_HEADER;
      ctr_q    <= '0;
      // NOTE: the board register is reset as well, so data_o reads zero right after reset.
      board_q  <= '0;
      frames_q <= '0;
    end else begin
      state_q  <= state_d;
      ctr_q    <= ctr_d;
      board_q  <= board_d;
      frames_q <= frames_d;
    end
  end

  assign ch.ready_and_o = (state_q != S_OUT);
  assign ch.v_o         = (state_q == S_OUT);
  assign ch.data_o      = board_q;
  assign ch.frames_o    = frames_q;

`ifdef BSG_CGOL_INPUT_PAD_CHECK_EN
  localparam int          last_bits_lp = num_total_cells_lp - 64 * (data_words_lp - 1);
  localparam logic [63:0] pad_mask_lp  = (last_bits_lp == 64) ? 64'd0
                                         : ~((64'd1 << last_bits_lp) - 64'd1);

  logic err_q, err_d;

  always_comb begin
    err_d = err_q;
    if (data_xfer && last_word && (|(ch.data_i & pad_mask_lp))) err_d = 1'b1;
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) err_q <= 1'b0;
    else            err_q <= err_d;
  end

  assign ch.err_o = err_q;
`else
  assign ch.err_o = 1'b0;
`endif

endmodule

// File: tb/tb_bsg_cgol_input_data_channel.sv
// Bench for the CGOL input data channel: directed and random streams against a
// transaction-level board model (10x10 board) plus a directed 8x8 run.
module tb_bsg_cgol_input_data_channel;

  localparam int n10 = 100;
  localparam int n8  = 64;
`ifdef BSG_CGOL_INPUT_PAD_CHECK_EN
  localparam bit pad_en = 1'b1;
`else
  localparam bit pad_en = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bsg_cgol_input_data_channel_if #(.cells_p(n10), .frames_width_p(32)) ch10 ();
  bsg_cgol_input_data_channel_if #(.cells_p(n8),  .frames_width_p(32)) ch8 ();

  bsg_cgol_input_data_channel #(.board_width_p(10), .frames_width_p(32)) u_dut10 (
    .clk_i    (clk),
    .reset_n_i(rst_n),
    .ch       (ch10)
  );

  bsg_cgol_input_data_channel #(.board_width_p(8), .frames_width_p(32)) u_dut8 (
    .clk_i    (clk),
    .reset_n_i(rst_n),
    .ch       (ch8)
  );

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model of the 10x10 channel: awaiting header, words received so far, board held.
  bit             m_hdr;
  int             m_idx;
  bit             m_valid;
  logic [n10-1:0] m_board;
  logic [31:0]    m_frames;
  bit             m_err;

  task automatic model_reset();
    m_hdr = 1'b1; m_idx = 0; m_valid = 1'b0; m_board = '0; m_frames = '0; m_err = 1'b0;
  endtask

  task automatic model_step(input logic v, input logic [63:0] d, input logic y);
    if (m_valid) begin
      if (y) begin
        m_valid = 1'b0;
        m_hdr   = 1'b1;
      end
    end else if (v) begin
      if (m_hdr) begin
        m_frames = d[31:0];
        m_hdr    = 1'b0;
        m_idx    = 0;
      end else begin
        for (int b = 0; b < 64; b++) begin
          if (m_idx * 64 + b < n10) m_board[m_idx * 64 + b] = d[b];
          else if (pad_en && d[b])  m_err = 1'b1;
        end
        if (m_idx == (n10 + 63) / 64 - 1) m_valid = 1'b1;
        else                              m_idx++;
      end
    end
  endtask

  // Inputs change 2 time units after a rising edge; the model advances on the edge that consumes them.
  task automatic cyc10(input logic v, input logic [63:0] d, input logic y);
    ch10.v_i = v; ch10.data_i = d; ch10.yumi_i = y;
    @(posedge clk);
    if (rst_n) model_step(v, d, y);
    #2;
  endtask

  task automatic cyc8(input logic v, input logic [63:0] d, input logic y);
    ch8.v_i = v; ch8.data_i = d; ch8.yumi_i = y;
    @(posedge clk);
    #2;
  endtask

  bit cmp_en = 1'b0;

  always @(negedge clk) begin
    if (cmp_en) begin
      check("v_o",         {127'd0, ch10.v_o},         {127'd0, m_valid});
      check("ready_and_o", {127'd0, ch10.ready_and_o}, {127'd0, !m_valid});
      check("data_o",      {28'd0, ch10.data_o},       {28'd0, m_board});
      check("frames_o",    {96'd0, ch10.frames_o},     {96'd0, m_frames});
      check("err_o",       {127'd0, ch10.err_o},       {127'd0, m_err});
      check("yumi_legal",  {127'd0, ch10.yumi_i & ~ch10.v_o}, 128'd0);
    end
  end

  logic [63:0] w0, w1;

  initial begin
    rst_n = 1'b0;
    ch10.v_i = 1'b0; ch10.data_i = '0; ch10.yumi_i = 1'b0;
    ch8.v_i  = 1'b0; ch8.data_i  = '0; ch8.yumi_i  = 1'b0;
    model_reset();
    cmp_en = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    check("rst_v10",      {127'd0, ch10.v_o},    128'd0);
    check("rst_data10",   {28'd0, ch10.data_o},  128'd0);
    check("rst_frames10", {96'd0, ch10.frames_o}, 128'd0);
    check("rst_err10",    {127'd0, ch10.err_o},  128'd0);
    check("rst_v8",       {127'd0, ch8.v_o},     128'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_rst", {127'd0, ch8.ready_and_o}, 128'd1);
    @(posedge clk);
    #2;

    // 8x8 board: single data word.
    cyc8(1'b1, 64'h5, 1'b0);
    check("b8_v_after_hdr", {127'd0, ch8.v_o}, 128'd0);
    cyc8(1'b1, 64'hDEADBEEF_0123_4567, 1'b0);
    check("b8_v",      {127'd0, ch8.v_o},         128'd1);
    check("b8_data",   {64'd0, ch8.data_o},       {64'd0, 64'hDEADBEEF_0123_4567});
    check("b8_frames", {96'd0, ch8.frames_o},     128'd5);
    check("b8_ready",  {127'd0, ch8.ready_and_o}, 128'd0);
    check("b8_err",    {127'd0, ch8.err_o},       128'd0);
    for (int i = 0; i < 3; i++) cyc8(1'b1, {$urandom, $urandom}, 1'b0);
    check("b8_hold", {64'd0, ch8.data_o}, {64'd0, 64'hDEADBEEF_0123_4567});
    cyc8(1'b0, 64'd0, 1'b1);
    check("b8_v_after_yumi",     {127'd0, ch8.v_o},         128'd0);
    check("b8_ready_after_yumi", {127'd0, ch8.ready_and_o}, 128'd1);
    cyc8(1'b0, 64'd0, 1'b0);

    // 10x10 board with bubbles 1,0,0,1,0,1.
    cyc10(1'b1, 64'd3, 1'b0);
    cyc10(1'b0, 64'd0, 1'b0);
    cyc10(1'b0, 64'd0, 1'b0);
    cyc10(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    cyc10(1'b0, 64'd0, 1'b0);
    check("b10_v_before_last", {127'd0, ch10.v_o}, 128'd0);
    cyc10(1'b1, 64'h0000_000F_0000_0001, 1'b0);
    check("b10_v",     {127'd0, ch10.v_o},      128'd1);
    check("b10_lo",    {64'd0, ch10.data_o[63:0]},  {64'd0, 64'hFFFF_FFFF_FFFF_FFFF});
    check("b10_hi",    {92'd0, ch10.data_o[99:64]}, {92'd0, 36'hF_0000_0001});
    check("b10_frames", {96'd0, ch10.frames_o}, 128'd3);
    check("b10_err",   {127'd0, ch10.err_o},    128'd0);
    check("model_pin", {28'd0, m_board}, {28'd0, 36'hF_0000_0001, 64'hFFFF_FFFF_FFFF_FFFF});

    // Backpressure: new data offered while the board waits.
    for (int i = 0; i < 10; i++) cyc10(1'b1, {$urandom, $urandom}, 1'b0);
    check("bp_ready", {127'd0, ch10.ready_and_o}, 128'd0);
    check("bp_hi",    {92'd0, ch10.data_o[99:64]}, {92'd0, 36'hF_0000_0001});
    cyc10(1'b0, 64'd0, 1'b1);
    check("bp_ready_after_yumi", {127'd0, ch10.ready_and_o}, 128'd1);
    cyc10(1'b1, 64'd7, 1'b0);
    cyc10(1'b1, {$urandom, $urandom}, 1'b0);
    cyc10(1'b1, {28'd0, 4'($urandom), $urandom}, 1'b0);
    check("bp_next_v", {127'd0, ch10.v_o}, 128'd1);
    cyc10(1'b0, 64'd0, 1'b1);

    // Reset after word0 discards the partial board.
    cyc10(1'b1, 64'd9, 1'b0);
    cyc10(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    rst_n = 1'b0;
    #1;
    check("mid_rst_v",    {127'd0, ch10.v_o},   128'd0);
    check("mid_rst_data", {28'd0, ch10.data_o}, 128'd0);
    model_reset();
    cyc10(1'b1, 64'd1, 1'b0);
    cyc10(1'b1, 64'd1, 1'b0);
    rst_n = 1'b1;
    w0 = 64'h0123_4567_89AB_CDEF;
    w1 = 64'h0000_000A_5555_AAAA;
    cyc10(1'b1, 64'd11, 1'b0);
    cyc10(1'b1, w0, 1'b0);
    cyc10(1'b1, w1, 1'b0);
    check("post_rst_lo",     {64'd0, ch10.data_o[63:0]},  {64'd0, w0});
    check("post_rst_hi",     {92'd0, ch10.data_o[99:64]}, {92'd0, 36'hA_5555_AAAA});
    check("post_rst_frames", {96'd0, ch10.frames_o}, 128'd11);
    cyc10(1'b0, 64'd0, 1'b1);

    // Padding bit 40 of the last word, then a clean board.
    cyc10(1'b1, 64'd2, 1'b0);
    cyc10(1'b1, 64'd0, 1'b0);
    cyc10(1'b1, 64'h0000_0100_0000_0000, 1'b0);
    check("pad_err",  {127'd0, ch10.err_o}, {127'd0, pad_en});
    check("pad_hi",   {92'd0, ch10.data_o[99:64]}, 128'd0);
    cyc10(1'b0, 64'd0, 1'b1);
    cyc10(1'b1, 64'd4, 1'b0);
    cyc10(1'b1, 64'd1, 1'b0);
    cyc10(1'b1, 64'd1, 1'b0);
    check("pad_err_sticky", {127'd0, ch10.err_o}, {127'd0, pad_en});
    cyc10(1'b0, 64'd0, 1'b1);

    // Random traffic with bubbles and backpressure.
    for (int i = 0; i < 3000; i++) begin
      logic        v, y;
      logic [63:0] d;
      v = ($urandom % 4) != 0;
      d = {$urandom, $urandom};
      if (!m_valid && !m_hdr && m_idx == 1 && ($urandom % 8) != 0) d[63:36] = '0;
      y = m_valid && (($urandom % 3) == 0);
      cyc10(v, d, y);
    end

    @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
